// File: rtl/uvma_apb_slv_mem_pkg.sv
// Shared types and elaboration helpers for the APB4 memory-backed completer.
package uvma_apb_slv_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   function automatic bit data_width_ok(input int dw);
      return (dw == 8) || (dw == 16) || (dw == 32) || (dw == 64);
   endfunction

   function automatic int addr_lsb(input int dw);
      return $clog2(dw / 8);
   endfunction

   function automatic int idx_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/uvma_apb_slv_mem_array.sv
// Word array with byte-lane write enables, combinational read, cleared by reset_n.
module uvma_apb_slv_mem_array #(
   parameter int DEPTH = 256,
   parameter int DW    = 32,
   parameter int IW    = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            we,
   input  logic [IW-1:0]   widx,
   input  logic [DW-1:0]   wdata,
   input  logic [DW/8-1:0] wstrb,
   input  logic [IW-1:0]   ridx,
   output logic [DW-1:0]   rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         for (int b = 0; b < DW / 8; b++) begin
            if (wstrb[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   assign rdata = mem[ridx];

endmodule

// File: rtl/uvma_apb_slv_mem.sv
// APB4 completer over a word-addressed memory with programmable wait states and
// error responses for out-of-range or misaligned addresses.
//
//   state | meaning
//   IDLE  | no transfer; a SETUP phase latches attributes and loads the wait counter
//   WAIT  | ACCESS phase, counting wait states down; psel drop aborts
//   RESP  | pready high for one cycle; the closing edge commits write and count
module uvma_apb_slv_mem
   import uvma_apb_slv_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 256,
   parameter int MAX_WAIT   = 15
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            psel,
   input  logic                            penable,
   input  logic                            pwrite,
   input  logic [ADDR_WIDTH-1:0]           paddr,
   input  logic [DATA_WIDTH-1:0]           pwdata,
   input  logic [DATA_WIDTH/8-1:0]         pstrb,
   input  logic [2:0]                      pprot,
   output logic                            pready,
   output logic [DATA_WIDTH-1:0]           prdata,
   output logic                            pslverr,
   input  logic [$clog2(MAX_WAIT+1)-1:0]   wait_cycles,
   output logic [15:0]                     xfer_count
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LSB    = addr_lsb(DATA_WIDTH);
   localparam int IW     = idx_w(MEM_DEPTH);
   localparam int WCW    = $clog2(MAX_WAIT + 1);
   localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(STRB_W - 1);

   if (!data_width_ok(DATA_WIDTH)) begin : g_bad_data_width
      $error("uvma_apb_slv_mem: DATA_WIDTH must be 8, 16, 32 or 64");
   end

   state_t state_q, state_d;
   logic [WCW-1:0]        wcnt_q, wcnt_d, wait_sat;
   logic                  write_q, err_q;
   logic [IW-1:0]         idx_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]     strb_q;
   logic                  setup, in_err;
   logic [IW-1:0]         in_idx;
   logic                  cur_write, cur_err;
   logic [IW-1:0]         cur_idx;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_we;
   logic                  unused_pprot;

   assign unused_pprot = ^pprot;

   assign setup    = psel & ~penable;
   assign in_idx   = paddr[LSB +: IW];
   assign in_err   = (|(paddr & LANE_MASK)) || (|(paddr >> (LSB + IW)));
   assign wait_sat = (wait_cycles > WCW'(MAX_WAIT)) ? WCW'(MAX_WAIT) : wait_cycles;

   // A zero-wait transfer goes IDLE->RESP, so the response is built from the live bus.
   assign cur_write = (state_q == IDLE) ? pwrite : write_q;
   assign cur_err   = (state_q == IDLE) ? in_err : err_q;
   assign cur_idx   = (state_q == IDLE) ? in_idx : idx_q;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         IDLE: begin
            if (setup) begin
               wcnt_d  = wait_sat;
               state_d = (wait_sat == '0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (!psel) begin
               wcnt_d  = '0;
               state_d = IDLE;
            end else if (penable) begin
               wcnt_d = wcnt_q - WCW'(1);
               if (wcnt_q <= WCW'(1)) state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         write_q <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
      end else if (state_q == IDLE && setup) begin
         write_q <= pwrite;
         err_q   <= in_err;
         idx_q   <= in_idx;
         wdata_q <= pwdata;
         strb_q  <= pstrb;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pready     <= 1'b0;
         pslverr    <= 1'b0;
         prdata     <= '0;
         xfer_count <= '0;
      end else begin
         pready  <= (state_d == RESP);
         pslverr <= (state_d == RESP) && cur_err;
         prdata  <= (state_d == RESP && !cur_write && !cur_err) ? mem_rdata : '0;
         if (state_q == RESP) xfer_count <= xfer_count + 16'd1;
      end
   end

   assign mem_we = (state_q == RESP) && write_q && !err_q;

   uvma_apb_slv_mem_array #(
      .DEPTH (MEM_DEPTH),
      .DW    (DATA_WIDTH),
      .IW    (IW)
   ) u_array (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (mem_we),
      .widx    (idx_q),
      .wdata   (wdata_q),
      .wstrb   (strb_q),
      .ridx    (cur_idx),
      .rdata   (mem_rdata)
   );

endmodule
